// File: rtl/posit_csr_pkg.sv
// Shared definitions for the posit Avalon-MM CSR block: register map,
// CTRL/STATUS bit positions, opcode and sequencer state encodings.
package posit_csr_pkg;

  // Word addresses of the software-visible registers
  localparam int unsigned ADDR_NUM1   = 0;
  localparam int unsigned ADDR_NUM2   = 1;
  localparam int unsigned ADDR_CTRL   = 2;
  localparam int unsigned ADDR_STATUS = 3;
  localparam int unsigned ADDR_RESULT = 4;
  localparam int unsigned ADDR_COUNT  = 5;

  // CTRL fields
  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_OP_LSB    = 1;
  localparam int unsigned CTRL_OP_MSB    = 2;
  localparam int unsigned CTRL_IE_BIT    = 3;

  // STATUS fields
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;
  localparam int unsigned STATUS_ERR_BIT  = 2;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } posit_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } csr_state_e;

endpackage

// File: rtl/posit_csr_regs.sv
// Avalon-MM register file for the posit CSR block: address decode,
// registered read mux, operand/opcode storage, RESULT capture and the
// sticky DONE/ERR bits. Optional interrupt enable/output under the
// POSIT_CSR_IRQ_EN macro.
module posit_csr_regs
  import posit_csr_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic              avs_read,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  input  logic              busy,
  input  logic              done_set,
  input  logic              err_set,
  input  logic [DATA_W-1:0] res_data,
  input  logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] num1,
  output logic [DATA_W-1:0] num2,
  output posit_op_e         op,
  output logic              start_req,
  output posit_op_e         start_op
`ifdef POSIT_CSR_IRQ_EN
  ,
  output logic              irq
`endif
);

  logic [DATA_W-1:0] num1_q, num1_d;
  logic [DATA_W-1:0] num2_q, num2_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  posit_op_e         op_q, op_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rvalid_q, rvalid_d;
`ifdef POSIT_CSR_IRQ_EN
  logic              ie_q, ie_d;
  logic              irq_q, irq_d;
`endif

  logic [31:0]       addr_ext;
  logic              wr_num1, wr_num2, wr_ctrl, wr_status;
  logic [DATA_W-1:0] rd_word;

  assign addr_ext  = 32'(avs_address);
  assign wr_num1   = avs_write && (addr_ext == ADDR_NUM1);
  assign wr_num2   = avs_write && (addr_ext == ADDR_NUM2);
  assign wr_ctrl   = avs_write && (addr_ext == ADDR_CTRL);
  assign wr_status = avs_write && (addr_ext == ADDR_STATUS);

  // START is a pulse; the opcode travels with it so a combined OP+START write uses the new OP
  assign start_req = wr_ctrl && avs_writedata[CTRL_START_BIT];
  assign start_op  = posit_op_e'(avs_writedata[CTRL_OP_MSB:CTRL_OP_LSB]);

  assign num1 = num1_q;
  assign num2 = num2_q;
  assign op   = op_q;

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
`ifdef POSIT_CSR_IRQ_EN
  assign irq = irq_q;
`endif

  // Read mux over current register contents, so a same-cycle write is not yet visible
  always_comb begin
    rd_word = '0;
    case (addr_ext)
      ADDR_NUM1:   rd_word = num1_q;
      ADDR_NUM2:   rd_word = num2_q;
      ADDR_CTRL: begin
        rd_word[CTRL_OP_MSB:CTRL_OP_LSB] = op_q;
`ifdef POSIT_CSR_IRQ_EN
        rd_word[CTRL_IE_BIT] = ie_q;
`endif
      end
      ADDR_STATUS: begin
        rd_word[STATUS_BUSY_BIT] = busy;
        rd_word[STATUS_DONE_BIT] = done_q;
        rd_word[STATUS_ERR_BIT]  = err_q;
      end
      ADDR_RESULT: rd_word = result_q;
      ADDR_COUNT:  rd_word = count;
      default:     rd_word = '0;
    endcase
  end

  // Next-state for storage registers, sticky bits and read response
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    num1_d   = num1_q;
    num2_d   = num2_q;
    op_d     = op_q;
    result_d = result_q;

    if (wr_num1) num1_d = avs_writedata;
    if (wr_num2) num2_d = avs_writedata;
    if (wr_ctrl) op_d   = start_op;
    if (done_set) result_d = res_data;

    // Sticky bits: W1C clears, but a set in the same cycle wins
    done_d = (done_q && !(wr_status && avs_writedata[STATUS_DONE_BIT])) || done_set;
    err_d  = (err_q  && !(wr_status && avs_writedata[STATUS_ERR_BIT]))  || err_set;

    rvalid_d = avs_read;
    rdata_d  = avs_read ? rd_word : '0;

`ifdef POSIT_CSR_IRQ_EN
    ie_d  = wr_ctrl ? avs_writedata[CTRL_IE_BIT] : ie_q;
    irq_d = ie_q && done_q;
`endif
  end

  // Register update with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      num1_q   <= '0;
      num2_q   <= '0;
      result_q <= '0;
      rdata_q  <= '0;
      op_q     <= ADD;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
`ifdef POSIT_CSR_IRQ_EN
      ie_q     <= 1'b0;
      irq_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      num1_q   <= num1_d;
      num2_q   <= num2_d;
      result_q <= result_d;
      rdata_q  <= rdata_d;
      op_q     <= op_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
`ifdef POSIT_CSR_IRQ_EN
      ie_q     <= ie_d;
      irq_q    <= irq_d;
`endif
    end
  end

endmodule

// File: rtl/posit_avmm_csr.sv
// Avalon-MM front end for a posit arithmetic unit. Holds the launch/await
// sequencer, the request registers driving the unit and the completion
// counter; register decode lives in posit_csr_regs.
// Optional interrupt output enabled by defining POSIT_CSR_IRQ_EN.
module posit_avmm_csr
  import posit_csr_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic              avs_read,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [1:0]        op_sel,
  output logic [DATA_W-1:0] op_num1,
  output logic [DATA_W-1:0] op_num2,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data
`ifdef POSIT_CSR_IRQ_EN
  ,
  output logic              irq
`endif
);

  csr_state_e        state_q, state_d;
  logic [DATA_W-1:0] req_num1_q, req_num1_d;
  logic [DATA_W-1:0] req_num2_q, req_num2_d;
  posit_op_e         req_op_q, req_op_d;
  logic [DATA_W-1:0] count_q, count_d;

  logic              busy, done_set, err_set, start_req;
  logic [DATA_W-1:0] num1, num2;
  posit_op_e         op, start_op;

  assign busy     = (state_q == ISSUE) || (state_q == WAIT);
  assign op_valid = (state_q == ISSUE);
  assign op_sel   = req_op_q;
  assign op_num1  = req_num1_q;
  assign op_num2  = req_num2_q;

  posit_csr_regs #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_regs (
    .clock             (clock),
    .reset_n           (reset_n),
    .avs_address       (avs_address),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_read          (avs_read),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .busy              (busy),
    .done_set          (done_set),
    .err_set           (err_set),
    .res_data          (res_data),
    .count             (count_q),
    .num1              (num1),
    .num2              (num2),
    .op                (op),
    .start_req         (start_req),
    .start_op          (start_op)
`ifdef POSIT_CSR_IRQ_EN
    ,
    .irq               (irq)
`endif
  );

  // Sequencer: snapshot the request on START, hold it through the handshake, await one result
  always_comb begin
    state_d    = state_q;
    req_num1_d = req_num1_q;
    req_num2_d = req_num2_q;
    req_op_d   = req_op_q;
    count_d    = count_q;
    done_set   = 1'b0;
    err_set    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d    = ISSUE;
          req_num1_d = num1;
          req_num2_d = num2;
          req_op_d   = start_op;
        end
      end
      ISSUE: begin
        err_set = start_req;
        if (op_ready) state_d = WAIT;
      end
      WAIT: begin
        err_set = start_req;
        if (res_valid) begin
          state_d  = IDLE;
          done_set = 1'b1;
          count_d  = count_q + DATA_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request and counter registers; reset drops any in-flight request at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      req_num1_q <= '0;
      req_num2_q <= '0;
      req_op_q   <= ADD;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_num1_q <= req_num1_d;
      req_num2_q <= req_num2_d;
      req_op_q   <= req_op_d;
      count_q    <= count_d;
    end
  end

  // Operand snapshot at START keeps num1/num2/op register writes from reaching an operation in flight.
  // (the op register itself is still consumed by software readback through u_regs)
  logic unused_op;
  assign unused_op = ^op;

endmodule

// File: tb/tb_posit_avmm_csr.sv
// Directed self-checking bench for posit_avmm_csr. Inputs are driven and
// outputs sampled on the falling clock edge; every bus task starts and ends
// at a falling edge and occupies exactly one cycle.
// Interrupt checks are compiled in when POSIT_CSR_IRQ_EN is defined.
module tb_posit_avmm_csr;

  localparam logic [2:0] A_NUM1   = 3'd0;
  localparam logic [2:0] A_NUM2   = 3'd1;
  localparam logic [2:0] A_CTRL   = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_RESULT = 3'd4;
  localparam logic [2:0] A_COUNT  = 3'd5;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_sel;
  logic [31:0] op_num1;
  logic [31:0] op_num2;
  logic        res_valid;
  logic [31:0] res_data;
`ifdef POSIT_CSR_IRQ_EN
  logic        irq;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clock = ~clock;

  posit_avmm_csr #(
    .ADDR_W (3),
    .DATA_W (32)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .avs_address       (avs_address),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_read          (avs_read),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .op_valid          (op_valid),
    .op_ready          (op_ready),
    .op_sel            (op_sel),
    .op_num1           (op_num1),
    .op_num2           (op_num2),
    .res_valid         (res_valid),
    .res_data          (res_data)
`ifdef POSIT_CSR_IRQ_EN
    ,
    .irq               (irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clock);
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clock);
    avs_read    = 1'b0;
    check({tag, "_rvalid"}, 32'(avs_readdatavalid), 32'd1);
    check(tag, avs_readdata, exp);
  endtask

  // Read and write the same register in one cycle
  task automatic rw(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp, input string tag);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    avs_read      = 1'b1;
    @(negedge clock);
    avs_write     = 1'b0;
    avs_read      = 1'b0;
    check(tag, avs_readdata, exp);
  endtask

  task automatic pulse_res(input logic [31:0] d);
    res_valid = 1'b1;
    res_data  = d;
    @(negedge clock);
    res_valid = 1'b0;
    res_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
    op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    repeat (3) @(negedge clock);

    // Reset state of outputs
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_op_sel", 32'(op_sel), 32'd0);
    check("rst_op_num1", op_num1, 32'd0);
    check("rst_op_num2", op_num2, 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    check("rst_rvalid", 32'(avs_readdatavalid), 32'd0);
`ifdef POSIT_CSR_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clock);
    for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, $sformatf("rst_reg%0d", a));

    // Basic add: ready already high, result two cycles after acceptance
    op_ready = 1'b1;
    wr(A_NUM1, 32'h4000_0000);
    wr(A_NUM2, 32'h4000_0000);
    wr(A_CTRL, 32'h1);
    check("t1_op_valid", 32'(op_valid), 32'd1);
    check("t1_op_sel", 32'(op_sel), 32'd0);
    check("t1_op_num1", op_num1, 32'h4000_0000);
    check("t1_op_num2", op_num2, 32'h4000_0000);
    @(negedge clock);
    check("t1_wait_op_valid", 32'(op_valid), 32'd0);
    @(negedge clock);
    pulse_res(32'h4800_0000);
    rd(A_STATUS, 32'h2, "t1_status");
    rd(A_RESULT, 32'h4800_0000, "t1_result");
    rd(A_COUNT, 32'd1, "t1_count");

    // Stalled handshake: request held stable, later NUM1 write does not leak through
    wr(A_STATUS, 32'h2);
    op_ready = 1'b0;
    wr(A_NUM1, 32'h1111_1111);
    wr(A_NUM2, 32'h2222_2222);
    wr(A_CTRL, 32'h5);
    check("t2_c1_op_valid", 32'(op_valid), 32'd1);
    check("t2_c1_op_sel", 32'(op_sel), 32'd2);
    check("t2_c1_op_num1", op_num1, 32'h1111_1111);
    check("t2_c1_op_num2", op_num2, 32'h2222_2222);
    wr(A_NUM1, 32'h1234_5678);
    check("t2_c2_op_valid", 32'(op_valid), 32'd1);
    check("t2_c2_op_num1", op_num1, 32'h1111_1111);
    rd(A_STATUS, 32'h1, "t2_status_busy");
    check("t2_c3_op_valid", 32'(op_valid), 32'd1);
    check("t2_c3_op_num2", op_num2, 32'h2222_2222);
    @(negedge clock);
    check("t2_c4_op_valid", 32'(op_valid), 32'd1);
    check("t2_c4_op_num1", op_num1, 32'h1111_1111);
    @(negedge clock);
    check("t2_c5_op_valid", 32'(op_valid), 32'd1);
    check("t2_c5_op_num1", op_num1, 32'h1111_1111);
    op_ready = 1'b1;
    @(negedge clock);
    op_ready = 1'b0;
    check("t2_wait_op_valid", 32'(op_valid), 32'd0);
    rd(A_NUM1, 32'h1234_5678, "t2_num1_reg");

    // START while busy: ignored, ERR set, W1C clears ERR
    wr(A_CTRL, 32'h1);
    check("t3_no_reissue", 32'(op_valid), 32'd0);
    check("t3_op_sel_held", 32'(op_sel), 32'd2);
    rd(A_STATUS, 32'h5, "t3_status_busy_err");
    pulse_res(32'hABCD_0001);
    rd(A_STATUS, 32'h6, "t3_status_done_err");
    wr(A_STATUS, 32'h4);
    rd(A_STATUS, 32'h2, "t3_status_err_clr");
    rd(A_COUNT, 32'd2, "t3_count");

    // Stray result while idle changes nothing
    pulse_res(32'hDEAD_BEEF);
    rd(A_RESULT, 32'hABCD_0001, "t4_result");
    rd(A_COUNT, 32'd2, "t4_count");
    rd(A_STATUS, 32'h2, "t4_status");

    // OP+START in one write, minimum latency, back-to-back START with read-before-write
    op_ready = 1'b1;
    wr(A_STATUS, 32'h2);
    wr(A_CTRL, 32'h7);
    check("t5_op_valid", 32'(op_valid), 32'd1);
    check("t5_op_sel_div", 32'(op_sel), 32'd3);
    @(negedge clock);
    pulse_res(32'h3C00_0000);
    check("t5_idle_op_valid", 32'(op_valid), 32'd0);
    rw(A_CTRL, 32'h3, 32'h6, "t5_ctrl_prewrite");
    check("t5_b2b_op_valid", 32'(op_valid), 32'd1);
    check("t5_b2b_op_sel_sub", 32'(op_sel), 32'd1);
    check("t5_b2b_op_num1", op_num1, 32'h1234_5678);
    @(negedge clock);
    pulse_res(32'h0000_0011);
    rd(A_COUNT, 32'd4, "t5_count");
    rd(A_RESULT, 32'h0000_0011, "t5_result");
    rd(A_STATUS, 32'h2, "t5_status");

    // Result during ISSUE is ignored
    op_ready = 1'b0;
    wr(A_CTRL, 32'h1);
    pulse_res(32'h0000_0099);
    rd(A_RESULT, 32'h0000_0011, "t6_issue_result");
    rd(A_STATUS, 32'h3, "t6_issue_status");

    // Reset while in WAIT; a late result afterwards is ignored
    op_ready = 1'b1;
    @(negedge clock);
    op_ready = 1'b0;
    check("t7_wait_op_valid", 32'(op_valid), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("t7_async_op_valid", 32'(op_valid), 32'd0);
    check("t7_async_op_num1", op_num1, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    pulse_res(32'h0000_0077);
    for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, $sformatf("t7_reg%0d", a));
    check("t7_op_valid", 32'(op_valid), 32'd0);

`ifdef POSIT_CSR_IRQ_EN
    // Interrupt: rises two cycles after result, set beats same-cycle W1C
    op_ready = 1'b1;
    wr(A_CTRL, 32'h8);
    rd(A_CTRL, 32'h8, "t8_ctrl_ie");
    wr(A_CTRL, 32'h9);
    @(negedge clock);
    pulse_res(32'h1);
    check("t8_irq_m1", 32'(irq), 32'd0);
    @(negedge clock);
    check("t8_irq_m2", 32'(irq), 32'd1);
    wr(A_CTRL, 32'h9);
    @(negedge clock);
    res_valid = 1'b1;
    res_data  = 32'h2;
    wr(A_STATUS, 32'h2);
    res_valid = 1'b0;
    check("t8_irq_held_a", 32'(irq), 32'd1);
    rd(A_COUNT, 32'd2, "t8_count");
    check("t8_irq_held_b", 32'(irq), 32'd1);
    rd(A_STATUS, 32'h2, "t8_status_done");
    wr(A_STATUS, 32'h2);
    @(negedge clock);
    check("t8_irq_fall", 32'(irq), 32'd0);
`else
    // Without the interrupt option CTRL bit3 is not stored
    wr(A_CTRL, 32'h8);
    rd(A_CTRL, 32'h0, "t8_ctrl_ie_absent");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/posit_avmm_csr.md
# posit_avmm_csr

Avalon-MM responder that puts a posit arithmetic unit behind the HPS lightweight bridge in place of free-running PIO exports. Software writes two 32-bit operands and an opcode, then writes a start bit. The block launches one operation over a valid/ready request channel and captures the response. It exposes busy, done and error status, the result, and a completion counter for polled or interrupt-driven readback.

## Interface
- `ADDR_W`, 3: word address width; registers occupy 0..5, addresses 6..7 read 0 and ignore writes.
- `DATA_W`, 32: operand, result and bus data width.
- `clock` in 1: single clock for bus and compute side.
- `reset_n` in 1: asynchronous, active-low reset.
- `avs_address` in `ADDR_W`: word address.
- `avs_write` in 1: write strobe.
- `avs_writedata` in `DATA_W`: write data.
- `avs_read` in 1: read strobe.
- `avs_readdata` out `DATA_W`: read data, valid with `avs_readdatavalid`.
- `avs_readdatavalid` out 1: one-cycle read response.
- `op_valid` out 1: request valid to the posit unit.
- `op_ready` in 1: the posit unit accepts the request.
- `op_sel` out 2: opcode: 0 add, 1 sub, 2 mul, 3 div.
- `op_num1` out `DATA_W`: first operand.
- `op_num2` out `DATA_W`: second operand.
- `res_valid` in 1: result strobe from the posit unit; there is no backpressure.
- `res_data` in `DATA_W`: result.
- `irq` out 1: only present with `POSIT_CSR_IRQ_EN`.

## Operation
- Register map, word addresses:
  - 0 NUM1: read/write.
  - 1 NUM2: read/write.
  - 2 CTRL: write bit0 START, which self-clears and reads 0. Bits[2:1] OP read/write. Bit3 IE read/write.
  - 3 STATUS: read-only except as noted. Bit0 BUSY. Bit1 DONE, sticky, write 1 to clear. Bit2 ERR, sticky, write 1 to clear.
  - 4 RESULT: read-only.
  - 5 COUNT: read-only, completed operations, wraps 0xFFFFFFFF to 0.
- FSM states and transitions:
  - IDLE: a START write goes to ISSUE.
  - ISSUE: holds `op_valid`=1. `op_valid && op_ready` goes to WAIT.
  - WAIT: on `res_valid`, goes to IDLE; RESULT is loaded, DONE is set and COUNT increments.
- On START in IDLE:
  - NUM1, NUM2 and OP are copied into the request registers.
  - `op_num1`, `op_num2` and `op_sel` hold those copies until the next START.
  - Later NUM1, NUM2 and OP writes do not disturb an operation in flight.
- A START in the same write as an OP change uses the new OP.
- START while BUSY (ISSUE or WAIT): ignored, and ERR is set.
- `res_valid` in IDLE or ISSUE: ignored. RESULT, DONE and COUNT are unchanged.
- BUSY=1 exactly in ISSUE and WAIT.
- A DONE W1C in the same cycle as a completion leaves DONE=1 (set wins). The same rule applies to ERR.
- Read and write in the same cycle: both are performed, and the read returns the pre-write value.
- Reset mid-operation:
  - Returns to IDLE and drops the in-flight request; `op_valid` goes to 0 asynchronously.
  - A late `res_valid` after reset is ignored.
- Reset values: all registers 0, `op_valid`=0, `op_sel`=0, `op_num1`=0, `op_num2`=0, `avs_readdata`=0, `avs_readdatavalid`=0, `irq`=0.

## Timing
- No waitrequest. Writes take effect at the clock edge where `avs_write` is sampled.
- Reads: `avs_readdatavalid` and `avs_readdata` are registered and appear in cycle N+1 for a read in cycle N.
- START written in cycle N: `op_valid`=1 and BUSY=1 from cycle N+1.
- `op_valid` stays high and operands stay stable until `op_ready` is sampled high.
- `res_valid` in cycle M: RESULT, DONE and COUNT are updated and BUSY=0 from cycle M+1.
- Minimum START-to-DONE latency is 3 cycles: `op_ready` already high, `res_valid` the cycle after acceptance.
- Back-to-back: a START written in cycle M+1 is legal and launches.

## Configuration
- `POSIT_CSR_IRQ_EN` defined:
  - The `irq` port exists, registered as `irq` = IE & DONE.
  - `irq` rises in cycle M+2 after `res_valid` in cycle M, and falls the cycle after DONE is cleared or IE is written 0.
- `POSIT_CSR_IRQ_EN` undefined:
  - No `irq` port.
  - CTRL bit3 is not stored and reads 0.

## Structure
- Shared package `posit_csr_pkg`:
  - Register address constants `ADDR_NUM1` .. `ADDR_COUNT`.
  - STATUS and CTRL bit-position constants.
  - Opcode enum `posit_op_e` (ADD, SUB, MUL, DIV).
  - FSM state enum `csr_state_e` (IDLE, ISSUE, WAIT).
- One sub-module, `posit_csr_regs`: the Avalon register decode, read mux and sticky-bit logic.
- The top holds the FSM, the request registers and the counter.

## Test plan
- Write NUM1=0x40000000, NUM2=0x40000000, CTRL=0x1 (add); model returns 0x48000000 two cycles after acceptance -> `op_sel`=0 while `op_valid` is asserted; STATUS reads 0x2, RESULT reads 0x48000000, COUNT reads 1.
- Hold `op_ready`=0 for 5 cycles after START -> `op_valid`, `op_num1` and `op_num2` stay stable; BUSY=1 throughout; a NUM1 write of 0x12345678 during the stall does not change `op_num1`.
- START while in WAIT -> no second `op_valid` handshake; STATUS bit2 reads 1; writing 0x4 to STATUS clears it to 0.
- Issue `res_valid` while IDLE with `res_data`=0xDEADBEEF -> RESULT, COUNT and DONE are unchanged.
- Deassert `reset_n` during WAIT, release it, then pulse `res_valid` -> `op_valid` is 0 immediately on reset; all registers read 0; DONE stays 0.
- With `POSIT_CSR_IRQ_EN`, IE=1: complete one op, then write 0x2 to STATUS in the same cycle as a second completion -> `irq` stays 1 and COUNT=2; a further 0x2 write drops `irq` the next cycle.
